aes_key_mem_mk: RTL and testbench

Multi-slot, word-serial AES key-expansion memory supporting AES-128, AES-192 and AES-256. It expands a cipher key into NUM_SLOTS independent round-key slots, generating one 32-bit schedule word per cycle through a shared external S-box port. The cipher datapath reads any valid slot combinationally while another slot is being expanded, so keys can be switched without re-expansion stalls.

---
 rtl/aes_key_mem_mk.sv | 184 ++++++++++++++++++
 tb/tb_aes_key_mem_mk.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_mem_mk.sv
// Multi-slot AES-128/192/256 key schedule store: one schedule word per cycle through a shared S-box,
// ready 43/49/55 cycles after init; init while busy is dropped, combinational reads of any valid slot.
module aes_key_mem_mk #(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [255:0]         key,
    input  logic [1:0]           keylen,
    input  logic                 init,
    input  logic [SLOT_W-1:0]    init_slot,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NUM_SLOTS-1:0] slot_valid,
    input  logic [SLOT_W-1:0]    rd_slot,
    input  logic [3:0]           round,
    output logic [127:0]         round_key,
    output logic [31:0]          sboxw,
    input  logic [31:0]          new_sboxw
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [1:0]           klen_q, klen_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [5:0]           i_q, i_d;
    logic [2:0]           j_q, j_d;
    logic [7:0]           rcon_q, rcon_d;
    logic [31:0]          win_q [8];
    logic [31:0]          win_d [8];
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           slot_klen_q [NUM_SLOTS];
    logic [31:0]          mem_q [NUM_SLOTS][60];

    logic [31:0] kw [8];
    logic [3:0]  nk;
    logic [5:0]  last_i;
    logic        init_ok;
    logic [7:0]  rcon_xt;
    logic [31:0] w_old, temp, w_new;
    logic [3:0]  rd_nr;
    logic [5:0]  rd_base;

    for (genvar m = 0; m < 8; m++) begin : g_kw
        assign kw[m] = key[255-32*m -: 32];
    end

    assign nk      = (klen_q == 2'd0) ? 4'd4  : (klen_q == 2'd1) ? 4'd6  : 4'd8;
    assign last_i  = (klen_q == 2'd0) ? 6'd43 : (klen_q == 2'd1) ? 6'd51 : 6'd59;
    assign init_ok = (keylen != 2'b11) && (32'(init_slot) < NUM_SLOTS);
    assign rcon_xt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // The window keeps W[i-1] in slot 7, so W[i-Nk] sits at index 8-Nk.
    always_comb begin
        w_old = (klen_q == 2'd0) ? win_q[4] : (klen_q == 2'd1) ? win_q[2] : win_q[0];
        temp  = win_q[7];
        if (j_q == 3'd0) begin
            temp = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0};
        end else if (klen_q == 2'd2 && j_q == 3'd4) begin
            temp = new_sboxw;
        end
        w_new = w_old ^ temp;
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        slot_d  = slot_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        win_d   = win_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (init) begin
                    if (init_ok) begin
                        klen_d             = keylen;
                        slot_d             = init_slot;
                        valid_d[init_slot] = 1'b0;
                        state_d            = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                case (klen_q)
                    2'd0:    for (int m = 0; m < 4; m++) win_d[m+4] = kw[m];
                    2'd1:    for (int m = 0; m < 6; m++) win_d[m+2] = kw[m];
                    default: for (int m = 0; m < 8; m++) win_d[m]   = kw[m];
                endcase
                i_d     = {2'b00, nk};
                j_d     = 3'd0;
                rcon_d  = 8'h01;
                state_d = S_GEN;
            end
            S_GEN: begin
                for (int k = 0; k < 7; k++) win_d[k] = win_q[k+1];
                win_d[7] = w_new;
                i_d      = i_q + 6'd1;
                j_d      = ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) rcon_d = rcon_xt;
                if (i_q == last_i) state_d = S_DONE;
            end
            S_DONE: begin
                valid_d[slot_q] = 1'b1;
                done_d          = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            slot_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            rcon_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < 8; k++) win_q[k] <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) slot_klen_q[s] <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            slot_q  <= slot_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            win_q   <= win_d;
            if (state_q == S_DONE) slot_klen_q[slot_q] <= klen_q;
        end
    end

    // Schedule storage is left unreset; stale contents are hidden by valid_q.
    always_ff @(posedge clk) begin
        if (reset_n && state_q == S_LOAD) begin
            for (int m = 0; m < 8; m++) begin
                if (4'(m) < nk) mem_q[slot_q][m] <= kw[m];
            end
        end else if (reset_n && state_q == S_GEN) begin
            mem_q[slot_q][i_q] <= w_new;
        end
    end

    always_comb begin
        round_key = '0;
        rd_nr     = 4'd0;
        rd_base   = {round, 2'b00};
        if (32'(rd_slot) < NUM_SLOTS) begin
            case (slot_klen_q[rd_slot])
                2'd0:    rd_nr = 4'd10;
                2'd1:    rd_nr = 4'd12;
                default: rd_nr = 4'd14;
            endcase
            if (valid_q[rd_slot] && round <= rd_nr) begin
                round_key = {mem_q[rd_slot][rd_base],         mem_q[rd_slot][rd_base + 6'd1],
                             mem_q[rd_slot][rd_base + 6'd2],  mem_q[rd_slot][rd_base + 6'd3]};
            end
        end
    end

    assign sboxw      = (state_q == S_GEN) ? win_q[7] : 32'h0;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign slot_valid = valid_q;

endmodule

// File: tb/tb_aes_key_mem_mk.sv
// Bench for aes_key_mem_mk: FIPS-197 style reference expansion with a computed S-box.
module tb_aes_key_mem_mk;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] key;
    logic [1:0]   keylen;
    logic         init;
    logic [0:0]   init_slot;
    logic         busy, done, err;
    logic [1:0]   slot_valid;
    logic [0:0]   rd_slot;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw, new_sboxw;

    logic [7:0]  sbox_tab [256];
    logic [31:0] exp_w [2][60];
    logic        exp_valid [2];
    int          exp_kl [2];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                        sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

    aes_key_mem_mk dut (
        .clk(clk), .reset_n(reset_n), .key(key), .keylen(keylen), .init(init),
        .init_slot(init_slot), .busy(busy), .done(done), .err(err),
        .slot_valid(slot_valid), .rd_slot(rd_slot), .round(round),
        .round_key(round_key), .sboxw(sboxw), .new_sboxw(new_sboxw)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h00;
        if (b != 8'h00) begin
            inv = 8'h01;
            for (int n = 0; n < 254; n++) inv = gmul(inv, b);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic model_expand(input int slot, input logic [1:0] kl, input logic [255:0] k);
        int nk, total;
        logic [31:0] t;
        logic [7:0]  rc;
        nk    = 4 + 2 * int'(kl);
        total = 4 * (nk + 7);
        for (int n = 0; n < nk; n++) exp_w[slot][n] = k[255-32*n -: 32];
        for (int n = nk; n < total; n++) begin
            t = exp_w[slot][n-1];
            if (n % nk == 0) begin
                rc = 8'h01;
                for (int p = 1; p < n / nk; p++) rc = gmul(rc, 8'h02);
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && n % nk == 4) begin
                t = subword(t);
            end
            exp_w[slot][n] = exp_w[slot][n-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int s, input int r);
        if (s > 1 || !exp_valid[s] || r > 10 + 2 * exp_kl[s]) return 128'h0;
        return {exp_w[s][4*r], exp_w[s][4*r+1], exp_w[s][4*r+2], exp_w[s][4*r+3]};
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; init = 1'b0; key = '0; keylen = 2'd0; init_slot = 1'b0;
        rd_slot = 1'b0; round = 4'd0;
        exp_valid[0] = 1'b0; exp_valid[1] = 1'b0; exp_kl[0] = 0; exp_kl[1] = 0;
        step(); step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        tests++; if (slot_valid !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b want 00", slot_valid); end
        tests++; if (sboxw !== 32'h0) begin fails++; $display("FAIL reset_sboxw: got %h want 0", sboxw); end
        for (int s = 0; s < 2; s++) begin
            rd_slot = 1'(s); round = 4'd0; #1;
            tests++; if (round_key !== 128'h0) begin fails++; $display("FAIL reset_rk slot%0d: got %h want 0", s, round_key); end
        end
        reset_n = 1'b1;
        step();
    endtask

    // Full expansion with per-cycle timing, S-box port and read-port checks, then a read sweep.
    task automatic test_expand(input int slot, input logic [1:0] kl, input logic [255:0] k, input int inject);
        int nk, g, other;
        logic [127:0] exp_val;
        logic [31:0]  exp_sb;
        logic [1:0]   exp_sv;
        nk    = 4 + 2 * int'(kl);
        g     = 4 * (nk + 7) - nk;
        other = slot ^ 1;
        key = k; keylen = kl; init_slot = 1'(slot); init = 1'b1;
        step();
        init = 1'b0;
        exp_valid[slot] = 1'b0;
        model_expand(slot, kl, k);
        for (int c = 1; c <= g + 3; c++) begin
            if (c == g + 3) begin exp_valid[slot] = 1'b1; exp_kl[slot] = int'(kl); end
            if (c == inject) begin
                key = rand_key(); keylen = 2'($urandom_range(0, 2)); init_slot = 1'(other); init = 1'b1;
            end else begin
                init = 1'b0;
            end
            if (c % 2 == 1) begin rd_slot = 1'(slot); round = 4'($urandom_range(0, 15)); end
            else begin rd_slot = 1'(other); round = 4'd10; end
            #1;
            exp_sb  = (c >= 2 && c <= g + 1) ? exp_w[slot][nk + c - 3] : 32'h0;
            exp_sv  = {exp_valid[1], exp_valid[0]};
            exp_val = exp_rk(int'(rd_slot), int'(round));
            tests++; if (busy !== (c <= g + 2)) begin fails++; $display("FAIL busy c%0d: got %b want %b", c, busy, c <= g + 2); end
            tests++; if (done !== (c == g + 3)) begin fails++; $display("FAIL done c%0d: got %b want %b", c, done, c == g + 3); end
            tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_busy c%0d: got %b want 0", c, err); end
            tests++; if (sboxw !== exp_sb) begin fails++; $display("FAIL sboxw c%0d: got %h want %h", c, sboxw, exp_sb); end
            tests++; if (slot_valid !== exp_sv) begin fails++; $display("FAIL valid c%0d: got %b want %b", c, slot_valid, exp_sv); end
            tests++; if (round_key !== exp_val) begin
                fails++; $display("FAIL rk_during c%0d slot%0d r%0d: got %h want %h", c, rd_slot, round, round_key, exp_val);
            end
            step();
        end
        init = 1'b0;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse_width: got %b want 0", done); end
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 16; r++) begin
                rd_slot = 1'(s); round = 4'(r); #1;
                exp_val = exp_rk(s, r);
                tests++; if (round_key !== exp_val) begin
                    fails++; $display("FAIL rk_sweep slot%0d r%0d: got %h want %h", s, r, round_key, exp_val);
                end
            end
        end
        step();
    endtask

    task automatic test_aes128();
        test_expand(0, 2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, -1);
        rd_slot = 1'b0; round = 4'd0; #1;
        tests++; if (round_key !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin fails++; $display("FAIL aes128_r0: got %h", round_key); end
        round = 4'd10; #1;
        tests++; if (round_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin fails++; $display("FAIL aes128_r10: got %h", round_key); end
        round = 4'd11; #1;
        tests++; if (round_key !== 128'h0) begin fails++; $display("FAIL aes128_r11: got %h want 0", round_key); end
    endtask

    task automatic test_aes192();
        test_expand(1, 2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, -1);
        rd_slot = 1'b1; round = 4'd12; #1;
        tests++; if (round_key !== 128'he98ba06f448c773c8ecc720401002202) begin fails++; $display("FAIL aes192_r12: got %h", round_key); end
        round = 4'd13; #1;
        tests++; if (round_key !== 128'h0) begin fails++; $display("FAIL aes192_r13: got %h want 0", round_key); end
    endtask

    task automatic test_aes256();
        test_expand(1, 2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, -1);
        rd_slot = 1'b1; round = 4'd14; #1;
        tests++; if (round_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin fails++; $display("FAIL aes256_r14: got %h", round_key); end
        rd_slot = 1'b0; round = 4'd10; #1;
        tests++; if (round_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin fails++; $display("FAIL aes256_slot0_r10: got %h", round_key); end
    endtask

    task automatic test_error();
        key = rand_key(); keylen = 2'b11; init_slot = 1'b0; init = 1'b1;
        #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_early: got %b want 0", err); end
        step();
        init = 1'b0;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b want 1", err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL err_busy: got %b want 0", busy); end
        tests++; if (slot_valid !== 2'b11) begin fails++; $display("FAIL err_valid: got %b want 11", slot_valid); end
        step();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL err_idle: got %b want 0", busy); end
        rd_slot = 1'b0; round = 4'd10; #1;
        tests++; if (round_key !== exp_rk(0, 10)) begin fails++; $display("FAIL err_rk: got %h want %h", round_key, exp_rk(0, 10)); end
    endtask

    task automatic test_busy_ignore();
        test_expand(0, 2'($urandom_range(0, 2)), rand_key(), 5);
    endtask

    task automatic test_reinit();
        test_expand(0, 2'($urandom_range(0, 2)), rand_key(), -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) test_expand(int'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), rand_key(), -1);
    endtask

    task automatic test_reset_mid();
        key = rand_key(); keylen = 2'($urandom_range(0, 2)); init_slot = 1'b1; init = 1'b1;
        step();
        init = 1'b0;
        repeat (20) step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset_n = 1'b0;
        step();
        exp_valid[0] = 1'b0; exp_valid[1] = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b want 0", done); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_mid_err: got %b want 0", err); end
        tests++; if (slot_valid !== 2'b00) begin fails++; $display("FAIL rst_mid_valid: got %b want 00", slot_valid); end
        tests++; if (sboxw !== 32'h0) begin fails++; $display("FAIL rst_mid_sboxw: got %h want 0", sboxw); end
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 16; r++) begin
                rd_slot = 1'(s); round = 4'(r); #1;
                tests++; if (round_key !== 128'h0) begin fails++; $display("FAIL rst_mid_rk slot%0d r%0d: got %h want 0", s, r, round_key); end
            end
        end
        reset_n = 1'b1;
        step(); step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_rst_busy: got %b want 0", busy); end
        tests++; if (slot_valid !== 2'b00) begin fails++; $display("FAIL post_rst_valid: got %b want 00", slot_valid); end
    endtask

    initial begin
        for (int b = 0; b < 256; b++) sbox_tab[b] = sbox_calc(8'(b));
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_error();
        test_busy_ignore();
        test_reinit();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
